// File: rtl/qar_mem_sys.sv
// rtl/qar_mem_sys.sv - qar_core memory system: word RAM, console TX FIFO and MMIO registers
// Optional CYCLE counter at 0xFFFF_0008 is built only when QAR_MEM_CYCLE_CNT_EN is defined.
module qar_mem_sys #(
  parameter int DEPTH_WORDS = 1024,
  parameter int FIFO_DEPTH  = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  input  logic        mem_we,
  output logic [31:0] mem_rdata,
  output logic [7:0]  con_data,
  output logic        con_valid,
  input  logic        con_ready
);

  localparam int AW = $clog2(DEPTH_WORDS);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);
  // MMIO word addresses (byte address >> 2)
  localparam logic [29:0] WA_TX   = 30'h3FFF_C000;
  localparam logic [29:0] WA_STAT = 30'h3FFF_C001;
  localparam logic [29:0] WA_CYC  = 30'h3FFF_C002;

  logic [31:0]   ram_q [DEPTH_WORDS];
  logic [7:0]    fifo_q [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          ovf_q, ovf_d;

  logic [AW-1:0] ram_idx;
  logic          ram_hit, is_tx, is_stat, is_cyc;
  logic          fifo_empty, fifo_full, pop, push, drop;
  logic [31:0]   stat_word, cycle_rd;
  logic          unused_addr_lsbs;

  assign ram_idx          = mem_addr[AW+1:2];
  assign ram_hit          = (mem_addr[31:AW+2] == '0);
  assign is_tx            = (mem_addr[31:2] == WA_TX);
  assign is_stat          = (mem_addr[31:2] == WA_STAT);
  assign is_cyc           = (mem_addr[31:2] == WA_CYC);
  assign unused_addr_lsbs = ^mem_addr[1:0];

  // A full FIFO still accepts a push when the sink drains a byte on the same edge
  assign fifo_empty = (count_q == '0);
  assign fifo_full  = (count_q == FULL_CNT);
  assign pop        = !fifo_empty && con_ready;
  assign push       = mem_we && is_tx && (!fifo_full || pop);
  assign drop       = mem_we && is_tx && fifo_full && !pop;

  assign con_valid = !fifo_empty;
  assign con_data  = fifo_empty ? 8'h00 : fifo_q[rd_ptr_q];
  assign stat_word = {19'h0, 5'(count_q), 5'h0, ovf_q, fifo_full, fifo_empty};

  // Combinational read mux: RAM, then MMIO registers, everything else reads zero
  always_comb begin
    mem_rdata = 32'h0;
    if (ram_hit) begin
      mem_rdata = ram_q[ram_idx];
    end else if (is_stat) begin
      mem_rdata = stat_word;
    end else if (is_cyc) begin
      mem_rdata = cycle_rd;
    end
  end

  // FIFO pointer/count/overflow next state; a drop wins over a same-edge clear
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    ovf_d    = ovf_q;
    if (push) wr_ptr_d = wr_ptr_q + PW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
    if (mem_we && is_stat && mem_wdata[2]) ovf_d = 1'b0;
    if (drop) ovf_d = 1'b1;
  end

  // FIFO control registers, cleared by reset (which also discards queued bytes)
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
    end
  end

  // FIFO byte storage; stale entries are invisible because con_data is gated by count
  always_ff @(posedge clk) begin
    if (push) fifo_q[wr_ptr_q] <= mem_wdata[7:0];
  end

  // RAM write port: contents survive reset, but a write coinciding with reset is dropped
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
    end else if (mem_we && ram_hit) begin
      ram_q[ram_idx] <= mem_wdata;
    end
  end

`ifdef QAR_MEM_CYCLE_CNT_EN
  logic [31:0] cycle_q, cycle_d;

  // Free-running cycle counter; a software write reloads it and counting resumes from there
  always_comb begin
    cycle_d = cycle_q + 32'd1;
    if (mem_we && is_cyc) cycle_d = mem_wdata;
  end

  // Cycle counter register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cycle_q <= '0;
    else        cycle_q <= cycle_d;
  end

  assign cycle_rd = cycle_q;
`else
  assign cycle_rd = 32'h0;
`endif

endmodule

// File: tb/tb_qar_mem_sys.sv
// tb/tb_qar_mem_sys.sv - self-checking bench for qar_mem_sys
module tb_qar_mem_sys;

  localparam int DEPTH_WORDS = 1024;
  localparam int FIFO_DEPTH  = 8;
  localparam logic [31:0] A_TX   = 32'hFFFF_0000;
  localparam logic [31:0] A_STAT = 32'hFFFF_0004;
  localparam logic [31:0] A_CYC  = 32'hFFFF_0008;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] mem_addr = 32'h0;
  logic [31:0] mem_wdata = 32'h0;
  logic        mem_we = 1'b0;
  logic [31:0] mem_rdata;
  logic [7:0]  con_data;
  logic        con_valid;
  logic        con_ready = 1'b0;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  qar_mem_sys #(.DEPTH_WORDS(DEPTH_WORDS), .FIFO_DEPTH(FIFO_DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we),
    .mem_rdata(mem_rdata), .con_data(con_data), .con_valid(con_valid), .con_ready(con_ready)
  );

  typedef struct {
    logic [31:0] waddr;
    logic [31:0] wdata;
    logic [31:0] raddr;
    logic [31:0] exp;
  } vec_t;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Single-cycle bus write; entered and left at posedge+1
  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    mem_addr = a; mem_wdata = d; mem_we = 1'b1;
    @(posedge clk); #1;
    mem_we = 1'b0;
  endtask

  task automatic rd(input logic [31:0] a, output logic [31:0] d);
    mem_addr = a; mem_we = 1'b0;
    #1;
    d = mem_rdata;
  endtask

  function automatic logic [31:0] exp_stat(input int n, input bit ov);
    logic [31:0] s;
    s = 32'h0;
    s[12:8] = n[4:0];
    s[2] = ov;
    s[1] = (n == FIFO_DEPTH);
    s[0] = (n == 0);
    return s;
  endfunction

  vec_t        vecs[9];
  logic [31:0] r;
  logic [31:0] a, d;
  logic [7:0]  exp_bytes[8];
  logic [7:0]  q_m[$];
  bit          ovf_m;
  logic [31:0] ram_m[16];
  int          thr, op;
  bit          we_r, pop_m;

  initial begin
    // ---------------- reset state ----------------
    #2;
    chk("reset_con_valid", {31'h0, con_valid}, 32'h0);
    chk("reset_con_data", {24'h0, con_data}, 32'h0);
    rd(A_STAT, r); chk("reset_stat", r, 32'h1);
    rd(A_CYC, r);  chk("reset_cycle", r, 32'h0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // ---------------- table-driven RAM / decode vectors ----------------
    vecs[0] = '{32'h0000_0010, 32'hDEAD_BEEF, 32'h0000_0013, 32'hDEAD_BEEF};
    vecs[1] = '{32'h0000_0000, 32'h1111_1111, 32'h0000_0000, 32'h1111_1111};
    vecs[2] = '{32'h0000_0FFC, 32'hA5A5_A5A5, 32'h0000_0FFE, 32'hA5A5_A5A5};
    vecs[3] = '{32'h0000_1000, 32'h1234_5678, 32'h0000_1000, 32'h0000_0000};
    vecs[4] = '{32'h0000_1000, 32'h8765_4321, 32'h0000_0000, 32'h1111_1111};
    vecs[5] = '{32'hFFFF_000C, 32'hCAFE_F00D, 32'hFFFF_000C, 32'h0000_0000};
    vecs[6] = '{32'h0000_0004, 32'h0BAD_F00D, A_TX,          32'h0000_0000};
    vecs[7] = '{32'h0000_0014, 32'h0102_0304, 32'h0000_0011, 32'hDEAD_BEEF};
    vecs[8] = '{32'h0000_0020, 32'h5555_AAAA, A_STAT,        32'h0000_0001};
    for (int i = 0; i < 9; i++) begin
      wr(vecs[i].waddr, vecs[i].wdata);
      rd(vecs[i].raddr, r);
      chk($sformatf("vec%0d", i), r, vecs[i].exp);
    end

    // ---------------- fill FIFO and overflow ----------------
    con_ready = 1'b0;
    for (int i = 0; i < 8; i++) wr(A_TX, 32'h41 + 32'(i));
    rd(A_STAT, r); chk("full_stat", r, 32'h0000_0802);
    wr(A_TX, 32'h49);
    rd(A_STAT, r); chk("overflow_stat", r, 32'h0000_0806);
    chk("overflow_head", {24'h0, con_data}, 32'h41);
    chk("overflow_valid", {31'h0, con_valid}, 32'h1);

    // ---------------- push while full with pop ----------------
    con_ready = 1'b1;
    wr(A_TX, 32'h4A);
    con_ready = 1'b0;
    rd(A_STAT, r); chk("full_pushpop_stat", r, 32'h0000_0806);
    chk("full_pushpop_head", {24'h0, con_data}, 32'h42);
    wr(A_STAT, 32'h4);
    rd(A_STAT, r); chk("ovf_clear_stat", r, 32'h0000_0802);

    // ---------------- drain ----------------
    for (int i = 0; i < 7; i++) exp_bytes[i] = 8'(8'h42 + i);
    exp_bytes[7] = 8'h4A;
    con_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      #1;
      chk($sformatf("drain%0d", i), {23'h0, con_valid, con_data}, {23'h0, 1'b1, exp_bytes[i]});
      @(posedge clk); #1;
    end
    chk("drained_valid", {31'h0, con_valid}, 32'h0);
    rd(A_STAT, r); chk("drained_stat", r, 32'h1);

    // ---------------- empty FIFO push with ready high ----------------
    wr(A_TX, 32'h5A);
    chk("bypass_valid", {31'h0, con_valid}, 32'h1);
    chk("bypass_data", {24'h0, con_data}, 32'h5A);
    @(posedge clk); #1;
    chk("bypass_popped", {31'h0, con_valid}, 32'h0);
    con_ready = 1'b0;

    // ---------------- CYCLE counter ----------------
    wr(A_CYC, 32'hFFFF_FFFE);
    for (int i = 0; i < 4; i++) begin
      rd(A_CYC, r);
`ifdef QAR_MEM_CYCLE_CNT_EN
      chk($sformatf("cycle%0d", i), r, 32'hFFFF_FFFE + 32'(i));
`else
      chk($sformatf("cycle%0d", i), r, 32'h0);
`endif
      @(posedge clk); #1;
    end

    // ---------------- randomized traffic vs reference model ----------------
    for (int i = 0; i < 16; i++) begin
      ram_m[i] = $urandom;
      wr(32'(i * 4), ram_m[i]);
    end
    q_m.delete();
    ovf_m = 1'b0;
    for (int i = 0; i < 800; i++) begin
      thr = (i < 200) ? 20 : (i < 400) ? 85 : (i < 600) ? 50 : 5;
      con_ready = ($urandom_range(0, 99) < thr);
      op = $urandom_range(0, 9);
      d = $urandom;
      we_r = 1'b0;
      case (op)
        0, 1:    begin a = 32'($urandom_range(0, 15) * 4 + $urandom_range(0, 3)); we_r = 1'b1; end
        2, 3, 9: a = 32'($urandom_range(0, 15) * 4 + $urandom_range(0, 3));
        4, 5, 6: begin a = A_TX; we_r = 1'b1; end
        7:       begin a = A_STAT; we_r = 1'b1; end
        default: a = A_STAT;
      endcase
      mem_addr = a; mem_wdata = d; mem_we = we_r;
      #1;
      if (a == A_STAT)    chk("rnd_stat", mem_rdata, exp_stat(q_m.size(), ovf_m));
      else if (a == A_TX) chk("rnd_tx_rd", mem_rdata, 32'h0);
      else                chk("rnd_ram", mem_rdata, ram_m[a[5:2]]);
      chk("rnd_valid", {31'h0, con_valid}, {31'h0, q_m.size() != 0});
      chk("rnd_data", {24'h0, con_data}, (q_m.size() != 0) ? {24'h0, q_m[0]} : 32'h0);
      pop_m = (q_m.size() != 0) && con_ready;
      if (pop_m) void'(q_m.pop_front());
      if (we_r && a == A_TX) begin
        if (q_m.size() < FIFO_DEPTH) q_m.push_back(d[7:0]);
        else ovf_m = 1'b1;
      end
      if (we_r && a == A_STAT && d[2]) ovf_m = 1'b0;
      if (we_r && a != A_TX && a != A_STAT) ram_m[a[5:2]] = d;
      @(posedge clk); #1;
      mem_we = 1'b0;
    end

    // ---------------- reset mid-operation ----------------
    con_ready = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    con_ready = 1'b0;
    wr(A_STAT, 32'h4);
    wr(A_TX, 32'h01); wr(A_TX, 32'h02); wr(A_TX, 32'h03);
    wr(32'h0000_0100, 32'h7777_7777);
    wr(32'h0000_0104, 32'h1111_2222);
    rd(A_STAT, r); chk("pre_reset_stat", r, 32'h0000_0300);
    #1;
    rst_n = 1'b0;
    #1;
    chk("async_reset_valid", {31'h0, con_valid}, 32'h0);
    chk("async_reset_data", {24'h0, con_data}, 32'h0);
    chk("async_reset_stat", mem_rdata, 32'h1);
    @(posedge clk); #1;
    wr(32'h0000_0104, 32'h9999_9999);
    wr(A_TX, 32'h77);
    chk("reset_tx_discard", {31'h0, con_valid}, 32'h0);
    rd(A_CYC, r); chk("reset_cycle2", r, 32'h0);
    rst_n = 1'b1;
    rd(32'h0000_0100, r); chk("ram_retained", r, 32'h7777_7777);
    rd(32'h0000_0104, r); chk("ram_write_in_reset", r, 32'h1111_2222);
    rd(A_STAT, r); chk("post_reset_stat", r, 32'h1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/qar_mem_sys.md
QAR_MEM_SYS -- requirements
Module: qar_mem_sys

Interface
REQ-001 The block SHALL have parameter DEPTH_WORDS, default 1024, RAM size in 32-bit words (power of two).
REQ-002 The block SHALL have parameter FIFO_DEPTH, default 8, console FIFO entries (power of two, 2..16).
REQ-003 The block SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-005 The block SHALL have port mem_addr, input, 32, byte address from qar_core.
REQ-006 The block SHALL have port mem_wdata, input, 32, write data from qar_core.
REQ-007 The block SHALL have port mem_we, input, 1, write enable from qar_core; a write commits at the clk edge where it is high.
REQ-008 The block SHALL have port mem_rdata, output, 32, read data to qar_core, combinational from mem_addr and current state.
REQ-009 The block SHALL have port con_data, output, 8, console byte at the FIFO head.
REQ-010 The block SHALL have port con_valid, output, 1, high when the FIFO is not empty.
REQ-011 The block SHALL have port con_ready, input, 1, console sink accepts con_data when high together with con_valid.

Function
REQ-012 Address decode SHALL ignore mem_addr[1:0]: RAM region is 0 .. DEPTH_WORDS*4-1; MMIO at 0xFFFF_0000 (CON_TX), 0xFFFF_0004 (CON_STAT), 0xFFFF_0008 (CYCLE); every other address SHALL read 0, and writes to it SHALL be ignored.
REQ-013 RAM reads SHALL be zero-latency: mem_rdata = word[mem_addr[log2(DEPTH_WORDS)+1:2]] in the same cycle.
REQ-014 RAM writes SHALL update the full word at the clk edge; a read of the same address in the following cycle SHALL return the new value.
REQ-015 A write to CON_TX SHALL push mem_wdata[7:0] into the FIFO unless the FIFO is full after the pop applied at the same edge.
REQ-016 A pop SHALL occur at each edge where con_valid and con_ready are both high; con_data SHALL present the next entry in the following cycle.
REQ-017 Simultaneous push and pop SHALL leave the count unchanged; when the FIFO is full, the push SHALL be accepted because the pop frees a slot.
REQ-018 When the FIFO is empty, a simultaneous push and con_ready SHALL NOT pop; the pushed byte SHALL appear on con_data with con_valid high in the next cycle.
REQ-019 A push to a full FIFO with no pop SHALL be dropped and SHALL set the sticky overflow flag.
REQ-020 FIFO read and write pointers SHALL wrap modulo FIFO_DEPTH; count SHALL be log2(FIFO_DEPTH)+1 bits, range 0..FIFO_DEPTH.
REQ-021 A CON_STAT read SHALL return bit0 = empty, bit1 = full, bit2 = overflow, bits[12:8] = count, all other bits 0.
REQ-022 A CON_STAT write with mem_wdata[2]=1 SHALL clear overflow; if a dropped push occurs at the same edge, overflow SHALL remain set.
REQ-023 A CON_TX read SHALL return 0.

Reset
REQ-024 Assertion of rst_n low SHALL asynchronously clear the FIFO pointers, count, overflow, and CYCLE, leaving con_valid = 0 and con_data = 0x00.
REQ-025 RAM contents SHALL NOT be reset.
REQ-026 Reset asserted mid-operation SHALL discard FIFO contents and any write in flight in that cycle.
REQ-027 mem_rdata SHALL follow REQ-012 and REQ-013 during reset; MMIO reads SHALL show the reset values.

Configuration
REQ-028 With macro QAR_MEM_CYCLE_CNT_EN defined, CYCLE SHALL be a 32-bit counter that increments every cycle after reset release and wraps 0xFFFF_FFFF -> 0.
REQ-029 With QAR_MEM_CYCLE_CNT_EN defined, a write to CYCLE SHALL load mem_wdata, with the increment resuming from that value on the next edge.
REQ-030 Without QAR_MEM_CYCLE_CNT_EN, CYCLE SHALL read 0, writes to it SHALL be ignored, and no counter flops SHALL be synthesised.

Verification
REQ-031 Write 0xDEADBEEF to 0x0000_0010, then read 0x0000_0013 in the next cycle -> mem_rdata = 0xDEADBEEF.
REQ-032 With con_ready=0, write 0x41..0x48 to CON_TX, then 0x49 -> CON_STAT reads 0x0000_0806 (count 8, full, overflow) and con_data = 0x41.
REQ-033 With the FIFO full, write CON_TX while con_ready=1 -> count stays 8, overflow unchanged, and the next con_data is the second byte.
REQ-034 With the FIFO empty and con_ready=1, write 0x5A to CON_TX -> one cycle later con_valid=1 and con_data=0x5A; the following cycle con_valid=0.
REQ-035 With QAR_MEM_CYCLE_CNT_EN defined, write 0xFFFF_FFFE to CYCLE -> reads on the next three cycles return 0xFFFF_FFFF, 0x0, 0x1; without the macro, all reads return 0.
REQ-036 Drop rst_n with 3 FIFO entries queued -> con_valid = 0 immediately and CON_STAT = 0x0000_0001; RAM data is retained.
